// File: rtl/seg7_frame_reader_pkg.sv
// Shared definitions for the seven-segment frame reader: active-low segment
// patterns for each hex digit, the invalid marker and the frame FSM states.
package seg7_frame_reader_pkg;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

   // Nibble reported for any pattern that is not one of the sixteen above.
   localparam logic [3:0] INVALID_NIBBLE = 4'h0;

   typedef enum logic {
      COLLECT = 1'b0,
      PRESENT = 1'b1
   } state_t;

   function automatic logic is_one_hot(input logic [3:0] sel);
      return (sel != 4'b0000) && ((sel & (sel - 4'd1)) == 4'b0000);
   endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Maps an active-low 7-segment pattern back to its hex nibble; patterns
// outside the decoder's table are flagged invalid and read as zero.
module seg7_encoder
   import seg7_frame_reader_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic [3:0] hex,
   output logic       is_valid
);

   always_comb begin
      hex      = INVALID_NIBBLE;
      is_valid = 1'b1;
      case (seg_n)
         SEG_0:   hex = 4'h0;
         SEG_1:   hex = 4'h1;
         SEG_2:   hex = 4'h2;
         SEG_3:   hex = 4'h3;
         SEG_4:   hex = 4'h4;
         SEG_5:   hex = 4'h5;
         SEG_6:   hex = 4'h6;
         SEG_7:   hex = 4'h7;
         SEG_8:   hex = 4'h8;
         SEG_9:   hex = 4'h9;
         SEG_A:   hex = 4'hA;
         SEG_B:   hex = 4'hB;
         SEG_C:   hex = 4'hC;
         SEG_D:   hex = 4'hD;
         SEG_E:   hex = 4'hE;
         SEG_F:   hex = 4'hF;
         default: is_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_frame_reader.sv
// Recovers the 16-bit value shown on a multiplexed 4-digit active-low display:
// stability filter per sample, digit capture, frame assembly, valid/ready output.
module seg7_frame_reader
   import seg7_frame_reader_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
)(
   input  logic        clock,
   input  logic        resetn,
   input  logic [6:0]  seg_n,
   input  logic [3:0]  dig_n,
   input  logic        frame_ready,
   output logic        frame_valid,
   output logic [15:0] frame_value,
   output logic [3:0]  frame_err,
   output logic        overrun
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [10:0]      sample_reg, prev_reg;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [3:0]       mask_reg, mask_next;
   logic [15:0]      work_val_reg, work_val_next;
   logic [3:0]       work_err_reg, work_err_next;
   state_t           state_reg, state_next;
   logic [15:0]      frame_value_reg, frame_value_next;
   logic [3:0]       frame_err_reg, frame_err_next;
   logic             overrun_reg, overrun_next;

   logic [3:0]       hex;
   logic             is_valid;
   logic             capture;
   logic [3:0]       cap_sel;
   logic             frame_done;
   logic             handshake;

   seg7_encoder u_encoder (
      .seg_n    (sample_reg[6:0]),
      .hex      (hex),
      .is_valid (is_valid)
   );

   // Counter saturates so a held digit is captured once, on the edge it hits the limit.
   always_comb begin
      cnt_next = '0;
      if (sample_reg == prev_reg)
         cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
   end

   assign capture    = (cnt_next == CNT_MAX) && (cnt_reg != CNT_MAX) &&
                       is_one_hot(~sample_reg[10:7]);
   assign cap_sel    = capture ? ~sample_reg[10:7] : 4'b0000;
   assign frame_done = capture && ((mask_reg | cap_sel) == 4'b1111);
   assign mask_next  = frame_done ? 4'b0000 : (mask_reg | cap_sel);
   assign handshake  = (state_reg == PRESENT) && frame_ready;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         assign work_val_next[4*gi +: 4] = cap_sel[gi] ? hex : work_val_reg[4*gi +: 4];
         assign work_err_next[gi]        = cap_sel[gi] ? ~is_valid : work_err_reg[gi];
      end
   endgenerate

   always_comb begin
      state_next       = state_reg;
      frame_value_next = frame_value_reg;
      frame_err_next   = frame_err_reg;
      overrun_next     = overrun_reg;
      case (state_reg)
         COLLECT: begin
            if (frame_done) begin
               frame_value_next = work_val_next;
               frame_err_next   = work_err_next;
               state_next       = PRESENT;
            end
         end
         PRESENT: begin
            if (frame_done && handshake) begin
               frame_value_next = work_val_next;
               frame_err_next   = work_err_next;
            end else if (frame_done) begin
               overrun_next = 1'b1;
            end else if (handshake) begin
               state_next = COLLECT;
            end
         end
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sample_reg      <= '1;
         prev_reg        <= '1;
         cnt_reg         <= '0;
         mask_reg        <= '0;
         work_val_reg    <= '0;
         work_err_reg    <= '0;
         state_reg       <= COLLECT;
         frame_value_reg <= '0;
         frame_err_reg   <= '0;
         overrun_reg     <= 1'b0;
      end else begin
         sample_reg      <= {dig_n, seg_n};
         prev_reg        <= sample_reg;
         cnt_reg         <= cnt_next;
         mask_reg        <= mask_next;
         work_val_reg    <= work_val_next;
         work_err_reg    <= work_err_next;
         state_reg       <= state_next;
         frame_value_reg <= frame_value_next;
         frame_err_reg   <= frame_err_next;
         overrun_reg     <= overrun_next;
      end
   end

   assign frame_valid = (state_reg == PRESENT);
   assign frame_value = frame_value_reg;
   assign frame_err   = frame_err_reg;
   assign overrun     = overrun_reg;

endmodule

// File: tb/tb_seg7_frame_reader.sv
// Directed bench for seg7_frame_reader: drives multiplexed digit sequences and
// checks assembled frames, latency, filtering, errors, overrun and reset.
module tb_seg7_frame_reader;

   localparam logic [6:0] PAT_0 = 7'b1000000;
   localparam logic [6:0] PAT_1 = 7'b1111001;
   localparam logic [6:0] PAT_2 = 7'b0100100;
   localparam logic [6:0] PAT_3 = 7'b0110000;
   localparam logic [6:0] PAT_4 = 7'b0011001;
   localparam logic [6:0] PAT_5 = 7'b0010010;
   localparam logic [6:0] PAT_6 = 7'b0000010;
   localparam logic [6:0] PAT_7 = 7'b1111000;
   localparam logic [6:0] PAT_8 = 7'b0000000;
   localparam logic [6:0] PAT_9 = 7'b0010000;
   localparam logic [6:0] PAT_A = 7'b0001000;
   localparam logic [6:0] PAT_B = 7'b0000011;
   localparam logic [6:0] PAT_C = 7'b1000110;
   localparam logic [6:0] PAT_D = 7'b0100001;
   localparam logic [6:0] PAT_E = 7'b0000110;
   localparam logic [6:0] PAT_F = 7'b0001110;
   localparam logic [6:0] PAT_X = 7'b1111111;

   logic        clock;
   logic        resetn;
   logic [6:0]  seg_n;
   logic [3:0]  dig_n;
   logic        frame_ready;
   logic        frame_valid;
   logic [15:0] frame_value;
   logic [3:0]  frame_err;
   logic        overrun;

   int checks = 0;
   int errors = 0;
   int hs_count = 0;
   int valid_cycles = 0;
   logic [15:0] hs_value = '0;
   logic [3:0]  hs_err = '0;
   int h0, v0;

   seg7_frame_reader #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .seg_n       (seg_n),
      .dig_n       (dig_n),
      .frame_ready (frame_ready),
      .frame_valid (frame_valid),
      .frame_value (frame_value),
      .frame_err   (frame_err),
      .overrun     (overrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Sampled mid-cycle: valid & ready here means a handshake on the coming edge.
   always @(negedge clock) begin
      if (frame_valid) valid_cycles++;
      if (frame_valid && frame_ready) begin
         hs_count++;
         hs_value = frame_value;
         hs_err   = frame_err;
         $display("frame accepted: value=%04h err=%04b", frame_value, frame_err);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int idx, input logic [6:0] pat, input int n);
      dig_n = ~(4'b0001 << idx);
      seg_n = pat;
      repeat (n) @(negedge clock);
   endtask

   task automatic blank(input int n);
      dig_n = 4'b1111;
      seg_n = PAT_X;
      repeat (n) @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn      = 1'b0;
      dig_n       = 4'b1111;
      seg_n       = PAT_X;
      frame_ready = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_valid", frame_valid, 0);
      check("rst_value", frame_value, 0);
      check("rst_err", frame_err, 0);
      check("rst_overrun", overrun, 0);
      resetn = 1'b1;

      // Frame 1234 with exact latency on the last digit
      frame_ready = 1'b1;
      blank(2);
      h0 = hs_count; v0 = valid_cycles;
      drive(0, PAT_4, 6); drive(1, PAT_3, 6); drive(2, PAT_2, 6);
      drive(3, PAT_1, 4);
      check("t1_not_yet", frame_valid, 0);
      drive(3, PAT_1, 1);
      check("t1_valid", frame_valid, 1);
      check("t1_value", frame_value, 16'h1234);
      check("t1_err", frame_err, 0);
      drive(3, PAT_1, 1);
      check("t1_drop", frame_valid, 0);
      blank(2);
      check("t1_pulse", valid_cycles - v0, 1);
      check("t1_hs", hs_count - h0, 1);

      // Digit 2 too short, then re-driven for exactly 4 cycles
      h0 = hs_count;
      drive(0, PAT_5, 6); drive(1, PAT_6, 6); drive(2, PAT_7, 3);
      blank(2); drive(3, PAT_8, 6); blank(3);
      check("t2_no_frame", frame_valid, 0);
      check("t2_no_hs", hs_count - h0, 0);
      drive(2, PAT_7, 4); blank(3);
      check("t2_hs", hs_count - h0, 1);
      check("t2_value", hs_value, 16'h8765);
      check("t2_err", hs_err, 0);

      // Non-hex pattern on digit 1
      drive(0, PAT_9, 6); drive(1, PAT_X, 6); drive(2, PAT_C, 6); drive(3, PAT_F, 6);
      blank(3);
      check("t3_value", hs_value, 16'hFC09);
      check("t3_err", hs_err, 4'b0010);

      // Held frame ABCD, second frame discarded as overrun
      frame_ready = 1'b0;
      drive(0, PAT_D, 6); drive(1, PAT_C, 6); drive(2, PAT_B, 6); drive(3, PAT_A, 6);
      blank(2);
      check("t4_valid", frame_valid, 1);
      check("t4_value", frame_value, 16'hABCD);
      check("t4_no_overrun", overrun, 0);
      drive(0, PAT_F, 6); drive(1, PAT_0, 6); drive(2, PAT_F, 6); drive(3, PAT_0, 6);
      blank(2);
      check("t4_hold_valid", frame_valid, 1);
      check("t4_hold_value", frame_value, 16'hABCD);
      check("t4_overrun", overrun, 1);
      frame_ready = 1'b1;
      @(negedge clock);
      check("t4_drop", frame_valid, 0);
      check("t4_hs_value", hs_value, 16'hABCD);

      // Handshake on the same edge that completes 5E5E
      frame_ready = 1'b0;
      drive(0, PAT_2, 6); drive(1, PAT_2, 6); drive(2, PAT_2, 6); drive(3, PAT_2, 6);
      blank(2);
      check("t5_held", frame_value, 16'h2222);
      drive(0, PAT_E, 6); drive(1, PAT_5, 6); drive(2, PAT_E, 6); drive(3, PAT_5, 4);
      dig_n = 4'b1111; seg_n = PAT_X; frame_ready = 1'b1;
      @(negedge clock);
      check("t5_valid", frame_valid, 1);
      check("t5_value", frame_value, 16'h5E5E);
      check("t5_hs_prev", hs_value, 16'h2222);
      @(negedge clock);
      check("t5_drop", frame_valid, 0);
      check("t5_hs_value", hs_value, 16'h5E5E);
      check("t5_sticky", overrun, 1);

      // Reset after three captures loses the partial frame
      drive(0, PAT_1, 6); drive(1, PAT_1, 6); drive(2, PAT_1, 6);
      resetn = 1'b0;
      #1;
      check("t6_valid", frame_valid, 0);
      check("t6_value", frame_value, 0);
      check("t6_err", frame_err, 0);
      check("t6_overrun", overrun, 0);
      @(negedge clock);
      resetn = 1'b1;
      h0 = hs_count;
      drive(3, PAT_1, 6); blank(3);
      check("t6_no_frame", frame_valid, 0);
      check("t6_no_hs", hs_count - h0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_frame_reader.md
Name: seg7_frame_reader

Overview:
- Receive-side counterpart of the hex-to-7-segment decoder: observes a multiplexed 4-digit, active-low 7-segment bus and recovers the 16-bit hex value being displayed.
- Per-digit stability filter, pattern-to-nibble encoding with invalid-pattern detection, and frame assembly.
- Output is a single-entry buffered valid/ready frame port.
- Used for display loopback checking and for reading seven-segment outputs from other lab blocks.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (legal range 2..255).
- CNT_W, 8, width of the stability counter; must hold STABLE_CYCLES-1.

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- seg_n  input  7  segment bus, active-low; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
- dig_n  input  4  digit enables, active-low; bit i low selects digit i (bit0 = least significant nibble).
- frame_ready  input  1  consumer accepts the frame.
- frame_valid  output  1  frame_value/frame_err hold a complete frame.
- frame_value  output  16  digit i occupies bits [4i+3:4i].
- frame_err  output  4  bit i set = digit i showed a non-hex pattern; its nibble reads 0.
- overrun  output  1  sticky: a completed frame was discarded; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): frame_valid=0, frame_value=0, frame_err=0, overrun=0, captured mask=0, stability counter=0, sample registers=all ones, state=COLLECT.
- Encoding, all active-low, seg_n[6:0]:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Any other pattern is invalid: nibble 0, err bit 1.
- Sampling:
  - {dig_n,seg_n} is registered every cycle.
  - If it equals the previous sample, the counter increments, saturating at STABLE_CYCLES-1. Otherwise the counter is 0.
- Capture:
  - Occurs exactly once, on the cycle the counter reaches STABLE_CYCLES-1, i.e. after STABLE_CYCLES identical consecutive samples.
  - The counter holds while input is unchanged, so there is no re-capture until the input changes.
  - Requires dig_n to have exactly one bit low. Blanking (4'b1111) and multi-select patterns never capture.
  - A capture writes working nibble i and err bit i, and sets mask bit i.
  - Re-capturing an already-set digit overwrites it.
- FSM COLLECT:
  - When a capture makes mask=4'b1111, load output registers from the working set, clear the mask, go to PRESENT.
  - frame_valid rises the cycle after the 4th capture.
- FSM PRESENT:
  - frame_valid=1; outputs stable while frame_valid & ~frame_ready.
  - Collection continues into the working set.
  - Handshake (valid & ready) with no frame completing that cycle: go to COLLECT, frame_valid=0 next cycle.
  - Frame completing on the same cycle as the handshake: load the new frame, stay in PRESENT, frame_valid stays 1.
  - Frame completing without the handshake: discard it, clear the mask, set overrun; the held frame is unchanged.
- Latency: input stable from cycle t, the 4th digit's capture occurs at the end of cycle t+STABLE_CYCLES; frame_valid is high in cycle t+STABLE_CYCLES+1.
- Reset asserted mid-frame: all partial state is lost immediately.

Decomposition:
- Shared include file: the 16 segment pattern constants, the invalid marker, and state encodings (COLLECT=0, PRESENT=1). The same constants are usable by the decoder and by testbenches.
- One combinational sub-module, seg7_encoder: seg_n[6:0] -> hex[3:0], is_valid.
- Stability filter, mask and FSM live in the top.

Test Plan:
- STABLE_CYCLES=4; drive digits 0..3 with patterns for 4,3,2,1 (0011001, 0110000, 0100100, 1111001), 6 cycles each, frame_ready=1 -> frame_valid pulses 1 cycle, frame_value=16'h1234, frame_err=0.
- Digit 2 held only 3 cycles then blanked, others 6 cycles -> no capture of digit 2, frame_valid stays 0; re-driving digit 2 for 4 cycles completes the frame.
- Digit 1 driven with 1111111 (blank pattern) -> frame_value[7:4]=0, frame_err=4'b0010.
- frame_ready=0 after frame 16'hABCD, then a full frame 16'h0F0F arrives -> outputs hold ABCD, overrun=1; raising ready drops valid next cycle.
- The handshake cycle coincides with completion of frame 16'h5E5E -> frame_valid stays 1 and frame_value updates to 16'h5E5E.
- resetn pulsed low after 3 digits captured -> all outputs 0 immediately; a following single digit capture does not produce a frame.
